// File: rtl/hwag_wheel_pkg.sv
// Shared defaults and helpers for the HWAG trigger-wheel generator.
package hwag_wheel_pkg;

  localparam int TEETH_DEF           = 60;
  localparam int MISSING_DEF         = 2;
  localparam int START_TOOTH_DEF     = 45;
  localparam int CAM_PHASE_TOOTH_DEF = 30;

  localparam int PRESC_W_DEF = 8;
  localparam int PER_W_DEF   = 8;
  localparam int TW_DEF      = 8;

  // Working width of the saturating adder; prescaler widths must stay below it.
  localparam int SAT_W = 32;

  // Unsigned current value plus signed step, clamped to [lo, hi]. The sum is
  // formed two bits wider than the operands so it can neither wrap nor
  // overflow before the clamp is applied.
  function automatic logic [SAT_W-1:0] sat_add(
    input logic        [SAT_W-1:0] cur,
    input logic signed [SAT_W-1:0] step,
    input logic        [SAT_W-1:0] lo,
    input logic        [SAT_W-1:0] hi
  );
    logic signed [SAT_W+1:0] sum;
    sum = $signed({2'b00, cur}) + $signed({{2{step[SAT_W-1]}}, step});
    if (sum < $signed({2'b00, lo})) begin
      return lo;
    end else if (sum > $signed({2'b00, hi})) begin
      return hi;
    end else begin
      return sum[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/hwag_wheel_presc.sv
// Prescaler for the trigger wheel: divides clk into ticks and ramps the
// division ratio by a signed step at every tooth end.
module hwag_wheel_presc
  import hwag_wheel_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc_top,
  input  logic [PRESC_W-1:0] presc_min,
  input  logic [PRESC_W-1:0] presc_max,
  input  logic [PRESC_W-1:0] ramp_step,
  input  logic               tooth_end,
  output logic               tick
);

  localparam int PAD = SAT_W - PRESC_W;

  logic              [PRESC_W-1:0] presc_cnt;
  logic              [PRESC_W-1:0] presc_cur;
  logic signed       [SAT_W-1:0]   step_ext;

  assign step_ext = $signed({{PAD{ramp_step[PRESC_W-1]}}, ramp_step});

  // A tick closes each prescaler cycle. The >= keeps the divider from running
  // the full counter range if presc_cur is ever reloaded below a frozen count.
  assign tick = en && (presc_cnt >= presc_cur);

  // Prescaler count and ramped division ratio; the ratio reloads while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt <= '0;
      presc_cur <= presc_top;
    end else if (!en) begin
      presc_cur <= presc_top;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
      if (tooth_end) begin
        presc_cur <= PRESC_W'(sat_add({{PAD{1'b0}}, presc_cur}, step_ext,
                                      {{PAD{1'b0}}, presc_min},
                                      {{PAD{1'b0}}, presc_max}));
      end
    end
  end

endmodule

// File: rtl/hwag_wheel_gen.sv
// Crank/cam trigger-wheel generator: missing-tooth VR crank output plus a
// cam output that is only active on every second crank revolution.
module hwag_wheel_gen
  import hwag_wheel_pkg::*;
#(
  parameter int TEETH           = TEETH_DEF,
  parameter int MISSING         = MISSING_DEF,
  parameter int PRESC_W         = PRESC_W_DEF,
  parameter int PER_W           = PER_W_DEF,
  parameter int TW              = TW_DEF,
  parameter int START_TOOTH     = START_TOOTH_DEF,
  parameter int CAM_PHASE_TOOTH = CAM_PHASE_TOOTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc_top,
  input  logic [PRESC_W-1:0] presc_min,
  input  logic [PRESC_W-1:0] presc_max,
  input  logic [PRESC_W-1:0] ramp_step,
  input  logic [PER_W-1:0]   tooth_period,
  input  logic [TW-1:0]      cam_on,
  input  logic [TW-1:0]      cam_off,
  output logic               vr_out,
  output logic               cam_out,
  output logic [TW-1:0]      tooth_idx,
  output logic               rev_stb,
  output logic               phase
);

  localparam int          LEN_W      = PER_W + 2;
  localparam logic [TW-1:0] LAST_TOOTH = TW'(TEETH - MISSING - 1);
  localparam logic [TW-1:0] FIRST_TOOTH = TW'(START_TOOTH);
  localparam logic [TW-1:0] PHASE_TOOTH = TW'(CAM_PHASE_TOOTH);

  logic [PER_W-1:0] per_sh;
  logic [TW-1:0]    cam_on_sh;
  logic [TW-1:0]    cam_off_sh;
  logic [LEN_W-1:0] tick_cnt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] half;
  logic [TW-1:0]    next_tooth;
  logic             tick;
  logic             last_tick;
  logic             tooth_end;

  hwag_wheel_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .presc_top (presc_top),
    .presc_min (presc_min),
    .presc_max (presc_max),
    .ramp_step (ramp_step),
    .tooth_end (tooth_end),
    .tick      (tick)
  );

  // Tooth length in ticks; the gap tooth absorbs the missing teeth.
  always_comb begin
    len = LEN_W'(per_sh);
    if (tooth_idx == LAST_TOOTH) begin
      len = LEN_W'(per_sh) * LEN_W'(MISSING + 1);
    end
    len_m1     = len - LEN_W'(1);
    half       = len_m1 >> 1;
    last_tick  = (tick_cnt == len_m1);
    tooth_end  = tick && last_tick;
    next_tooth = (tooth_idx == LAST_TOOTH) ? '0 : tooth_idx + TW'(1);
  end

  // Tick position within the tooth, tooth index and the VR edge pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt  <= '0;
      tooth_idx <= FIRST_TOOTH;
      vr_out    <= 1'b0;
    end else if (tick) begin
      if (last_tick) begin
        tick_cnt  <= '0;
        vr_out    <= 1'b0;
        tooth_idx <= next_tooth;
      end else begin
        tick_cnt <= tick_cnt + LEN_W'(1);
        if (tick_cnt == half) begin
          vr_out <= 1'b1;
        end
      end
    end
  end

  // Per-tooth configuration is captured at tooth boundaries so a tooth never
  // sees its length or cam edges change part-way through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_sh     <= tooth_period;
      cam_on_sh  <= cam_on;
      cam_off_sh <= cam_off;
    end else if (tooth_end) begin
      per_sh     <= tooth_period;
      cam_on_sh  <= cam_on;
      cam_off_sh <= cam_off;
    end
  end

  // Tooth-entry events: revolution strobe, cam phase and cam edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rev_stb <= 1'b0;
      phase   <= 1'b0;
      cam_out <= 1'b1;
    end else begin
      rev_stb <= tooth_end && (next_tooth == '0);
      if (tooth_end) begin
        if (next_tooth == PHASE_TOOTH) begin
          phase <= ~phase;
        end
        if (phase) begin
          if (next_tooth == cam_on_sh) begin
            cam_out <= 1'b1;
          end else if (next_tooth == cam_off_sh) begin
            cam_out <= 1'b0;
          end
        end
      end
    end
  end

endmodule
